// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine -- SD native-mode CMD-line engine.
//   Builds and shifts out the 48-bit command frame {0,1,index,arg,crc7,1},
//   then captures a 48-bit response, a 136-bit response or no response.
//   Each transaction ends with a status report and an idle NCC gap.
//   The engine also generates the card clock sd_cclk.
//
//   Optional feature macro: SD_CMD_RESP_CRC_CHECK_EN
//     defined   : the CRC7 of a 48-bit response is checked (status 2 on mismatch).
//                 The check is skipped for CMD41/R3.
//     undefined : no response CRC logic is built.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   fast_mode           divider select (0 SLOW_HZ, 1 FAST_HZ), latched in IDLE
//   cmd_valid/ready     command handshake
//   cmd_index, cmd_arg  command fields
//   resp_type           0/3 none, 1 48-bit, 2 136-bit
//   resp_valid          one-clk pulse, resp_status/resp_data valid
//   resp_status         0 ok, 1 timeout, 2 CRC error, 3 end-bit error
//   resp_data           received bits, right-aligned
//   sd_cclk             card clock
//   sd_cmd_o/oe/i       CMD pad drive value, output enable, input
module sd_cmd_engine #(
   parameter int CLK_HZ       = 100000000,
   parameter int SLOW_HZ      = 400000,
   parameter int FAST_HZ      = 25000000,
   parameter int INIT_CLKS    = 80,
   parameter int TIMEOUT_CLKS = 64,
   parameter int NCC_CLKS     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         fast_mode,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [5:0]   cmd_index,
   input  logic [31:0]  cmd_arg,
   input  logic [1:0]   resp_type,
   output logic         resp_valid,
   output logic [1:0]   resp_status,
   output logic [135:0] resp_data,
   output logic         sd_cclk,
   output logic         sd_cmd_o,
   output logic         sd_cmd_oe,
   input  logic         sd_cmd_i
);

   localparam int TC_SLOW_RAW = CLK_HZ / (2 * SLOW_HZ) - 1;
   localparam int TC_FAST_RAW = CLK_HZ / (2 * FAST_HZ) - 1;
   localparam int TC_SLOW     = (TC_SLOW_RAW < 1) ? 1 : TC_SLOW_RAW;
   localparam int TC_FAST     = (TC_FAST_RAW < 1) ? 1 : TC_FAST_RAW;
   localparam int TC_MAX      = (TC_SLOW > TC_FAST) ? TC_SLOW : TC_FAST;
   localparam int DIV_W       = $clog2(TC_MAX + 1);

   localparam logic [7:0] INIT_N   = 8'(INIT_CLKS);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CLKS - 1);
   localparam logic [7:0] NCC_N    = 8'(NCC_CLKS);

   localparam logic [1:0] ST_OK  = 2'd0;
   localparam logic [1:0] ST_TMO = 2'd1;
   localparam logic [1:0] ST_END = 2'd3;

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_SEND, S_WAIT, S_RECV, S_GAP} state_t;

   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return c;
   endfunction

   state_t           state_q;
   logic             fast_q;
   logic [DIV_W-1:0] div_cnt_q;
   logic             cclk_q;
   logic [7:0]       bcnt_q;
   logic [46:0]      tx_q;
   logic [134:0]     rx_q;
   logic             need_resp_q;
   logic             long_q;
   logic             cmd_ready_q;
   logic             resp_valid_q;
   logic [1:0]       resp_status_q;
   logic [135:0]     resp_data_q;
   logic             cmd_o_q;
   logic             cmd_oe_q;

   logic [DIV_W-1:0] tc;
   logic             tick, rise, fall;
   logic [39:0]      hdr;
   logic [47:0]      frame;
   logic [135:0]     rx_nxt;
   logic             rx_last;
   logic             crc_bad;

   assign tc   = fast_q ? DIV_W'(TC_FAST) : DIV_W'(TC_SLOW);
   // The clock runs in every state except IDLE; rise/fall flag the edge
   // that the sd_cclk register takes at the end of this cycle.
   assign tick = (state_q != S_IDLE) && (div_cnt_q == tc);
   assign rise = tick && !cclk_q;
   assign fall = tick && cclk_q;

   assign hdr     = {2'b01, cmd_index, cmd_arg};
   assign frame   = {hdr, crc7(hdr), 1'b1};
   assign rx_nxt  = {rx_q, sd_cmd_i};
   assign rx_last = bcnt_q == (long_q ? 8'd135 : 8'd47);

`ifdef SD_CMD_RESP_CRC_CHECK_EN
   logic r3_q;
   // R3 carries 7'h7F in the CRC field, so it is exempt from the check.
   assign crc_bad = !long_q && !r3_q && (crc7(rx_nxt[47:8]) != rx_nxt[7:1]);
`else
   assign crc_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_INIT;
         fast_q        <= 1'b0;
         div_cnt_q     <= '0;
         cclk_q        <= 1'b0;
         bcnt_q        <= '0;
         tx_q          <= '0;
         rx_q          <= '0;
         need_resp_q   <= 1'b0;
         long_q        <= 1'b0;
         cmd_ready_q   <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_status_q <= ST_OK;
         resp_data_q   <= '0;
         cmd_o_q       <= 1'b1;
         cmd_oe_q      <= 1'b0;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
         r3_q          <= 1'b0;
`endif
      end else begin
         resp_valid_q <= 1'b0;

         if (state_q == S_IDLE) begin
            div_cnt_q <= '0;
            cclk_q    <= 1'b0;
         end else if (tick) begin
            div_cnt_q <= '0;
            cclk_q    <= ~cclk_q;
         end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
         end

         case (state_q)
            S_INIT: begin
               cmd_oe_q <= 1'b1;
               cmd_o_q  <= 1'b1;
               if (rise) bcnt_q <= bcnt_q + 1'b1;
               // Leave on the falling edge so the last high phase is full length.
               if (fall && bcnt_q == INIT_N) begin
                  bcnt_q      <= '0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end

            S_IDLE: begin
               // The clock is parked low here, so switching rate cannot cut a pulse.
               fast_q <= fast_mode;
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  cmd_o_q     <= frame[47];
                  cmd_oe_q    <= 1'b1;
                  tx_q        <= frame[46:0];
                  rx_q        <= '0;
                  bcnt_q      <= '0;
                  need_resp_q <= (resp_type == 2'd1) || (resp_type == 2'd2);
                  long_q      <= (resp_type == 2'd2);
`ifdef SD_CMD_RESP_CRC_CHECK_EN
                  r3_q        <= (cmd_index == 6'd41);
`endif
                  state_q     <= S_SEND;
               end
            end

            S_SEND: begin
               if (fall) begin
                  if (bcnt_q == 8'd47) begin
                     bcnt_q <= '0;
                     if (need_resp_q) begin
                        cmd_oe_q <= 1'b0;
                        state_q  <= S_WAIT;
                     end else begin
                        cmd_o_q       <= 1'b1;
                        resp_valid_q  <= 1'b1;
                        resp_status_q <= ST_OK;
                        resp_data_q   <= '0;
                        state_q       <= S_GAP;
                     end
                  end else begin
                     cmd_o_q <= tx_q[46];
                     tx_q    <= {tx_q[45:0], 1'b1};
                     bcnt_q  <= bcnt_q + 1'b1;
                  end
               end
            end

            S_WAIT: begin
               if (rise) begin
                  if (!sd_cmd_i) begin
                     // Start bit is bit 1 of the response; rx_q is already zero.
                     bcnt_q  <= 8'd1;
                     state_q <= S_RECV;
                  end else if (bcnt_q == TMO_LAST) begin
                     bcnt_q        <= '0;
                     cmd_oe_q      <= 1'b1;
                     cmd_o_q       <= 1'b1;
                     resp_valid_q  <= 1'b1;
                     resp_status_q <= ST_TMO;
                     resp_data_q   <= '0;
                     state_q       <= S_GAP;
                  end else begin
                     bcnt_q <= bcnt_q + 1'b1;
                  end
               end
            end

            S_RECV: begin
               if (rise) begin
                  rx_q <= rx_nxt[134:0];
                  if (rx_last) begin
                     bcnt_q        <= '0;
                     cmd_oe_q      <= 1'b1;
                     cmd_o_q       <= 1'b1;
                     resp_valid_q  <= 1'b1;
                     resp_data_q   <= rx_nxt;
                     resp_status_q <= !rx_nxt[0] ? ST_END :
                                      crc_bad    ? 2'd2   : ST_OK;
                     state_q       <= S_GAP;
                  end else begin
                     bcnt_q <= bcnt_q + 1'b1;
                  end
               end
            end

            S_GAP: begin
               if (rise) bcnt_q <= bcnt_q + 1'b1;
               if (fall && bcnt_q == NCC_N) begin
                  bcnt_q      <= '0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end

            default: state_q <= S_INIT;
         endcase
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign resp_valid  = resp_valid_q;
   assign resp_status = resp_status_q;
   assign resp_data   = resp_data_q;
   assign sd_cclk     = cclk_q;
   assign sd_cmd_o    = cmd_o_q;
   assign sd_cmd_oe   = cmd_oe_q;

endmodule
